// File: rtl/hm10_uart_rx_fifo.sv
// hm10_uart_rx_fifo
// Receive front end for the HM-10 Bluetooth link. Deserialises the 8N1 stream
// on fpga_rxd and queues received bytes in a first-word-fall-through FIFO.
//
// Ports
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   fpga_rxd     serial input from the HM-10 TXD pin (asynchronous, idles high)
//   rd_en        pop the head byte (ignored while empty)
//   clear_flags  one-cycle pulse clearing frame_err and overflow
//   rd_data      head byte, 0 while empty
//   empty/full   FIFO occupancy flags
//   count        number of stored bytes (0 .. 2^ADDR_W)
//   rx_busy      receiver FSM is not idle
//   frame_err    sticky: a stop bit was sampled low
//   overflow     sticky: a good byte was dropped because the FIFO was full
//
// Handshake: a byte is available whenever empty=0 and is presented on rd_data;
// holding rd_en high at a rising edge consumes it, and the next byte (or the
// empty indication) appears after that edge.
module hm10_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              fpga_rxd,
  input  logic              rd_en,
  input  logic              clear_flags,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Synchroniser and arming
  logic        sync1, rxs;
  logic [1:0]  warm;
  logic        armed;

  // The synchroniser resets to 1, which says nothing about the real line, so
  // arming waits until two edges have filled the synchroniser from the pin.
  // A line held low across reset release thus never starts a frame.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync1 <= fpga_rxd;
      rxs   <= sync1;
      warm  <= {warm[0], 1'b1};
      if (warm[1] && rxs) armed <= 1'b1;
    end
  end

  // Receiver FSM
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              cnt_clr, idx_clr, shift_en, push, ferr_set;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (armed && !rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          state_n = rxs ? IDLE : DATA;   // high at mid-start is a glitch
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt == BIT_END) begin
          cnt_clr = 1'b1;
          state_n = IDLE;
          if (rxs) push     = 1'b1;
          else     ferr_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (idx_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift[bit_idx] <= rxs;
    end
  end

  assign rx_busy = (state != IDLE);

  // FIFO
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              do_push, do_pop, ovf_set;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = rd_en && !empty;
  // When full, a pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || rd_en);
  assign ovf_set = push && full && !rd_en;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  // Memory is not reset, so mask the head while empty.
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set event wins over a coincident clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ferr_set)         frame_err <= 1'b1;
      else if (clear_flags) frame_err <= 1'b0;
      if (ovf_set)          overflow  <= 1'b1;
      else if (clear_flags) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hm10_uart_rx_fifo.sv
// Self-checking bench for hm10_uart_rx_fifo: drives 8N1 frames on the serial
// pin and compares the FIFO/flag outputs with a queue-based reference model.
module tb_hm10_uart_rx_fifo;

  localparam int C     = 104;
  localparam int H     = C / 2;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          resetn;
  logic          fpga_rxd;
  logic          rd_en;
  logic          clear_flags;
  logic [7:0]    rd_data;
  logic          empty, full;
  logic [AW:0]   count;
  logic          rx_busy, frame_err, overflow;

  hm10_uart_rx_fifo #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .fpga_rxd(fpga_rxd), .rd_en(rd_en),
    .clear_flags(clear_flags), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .rx_busy(rx_busy), .frame_err(frame_err), .overflow(overflow)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic       m_ferr, m_ovf;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
  endfunction

  // Effect of one complete frame, with rd_en / clear_flags optionally held
  // during the cycle the stop bit is judged.
  task automatic model_frame(input logic [7:0] b, input logic good,
                             input logic rd, input logic clr);
    if (clr) begin m_ferr = 1'b0; m_ovf = 1'b0; end
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!good)                    m_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                          m_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"},     32'(count),     32'(exp_q.size()));
    check({tag, " empty"},     32'(empty),     32'(exp_q.size() == 0));
    check({tag, " full"},      32'(full),      32'(exp_q.size() == DEPTH));
    check({tag, " rd_data"},   32'(rd_data),   32'(exp_head()));
    check({tag, " frame_err"}, 32'(frame_err), 32'(m_ferr));
    check({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, " rx_busy"},   32'(rx_busy),   32'd0);
  endtask

  // drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    fpga_rxd = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fpga_rxd = 1'b0;
    repeat (C) step();
    for (int i = 0; i < 8; i++) begin
      fpga_rxd = b[i];
      repeat (C) step();
    end
    fpga_rxd = stop_bit;
    repeat (C) step();
    fpga_rxd = 1'b1;
  endtask

  task automatic send_with_pulse(input logic [7:0] b, input logic good,
                                 input logic rd, input logic clr);
    fork
      send_frame(b, good);
      begin : pulser
        int n;
        n = 0;
        while (!rx_busy && n < 400) begin step(); n++; end
        check("busy_start", 32'(rx_busy), 32'd1);
        if (rx_busy) begin
          // first busy cycle is T0+1; the stop sample is at T0+H+9C
          repeat (H + 9 * C - 1) step();
          rd_en = rd;
          clear_flags = clr;
          step();
          rd_en = 1'b0;
          clear_flags = 1'b0;
        end
      end
    join
    model_frame(b, good, rd, clr);
    // a low stop bit makes the idle FSM see a start; let that glitch die out
    idle(good ? 8 : 80);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic read_n(input int n, input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, " head"}, 32'(rd_data), 32'(exp_head()));
      step();
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    rd_en = 1'b0;
    check({tag, " count_after"}, 32'(count), 32'(exp_q.size()));
  endtask

  // stimulus
  int lat, len, busy_seen, push_seen;

  initial begin
    resetn = 1'b0; fpga_rxd = 1'b1; rd_en = 1'b0; clear_flags = 1'b0;
    m_ferr = 1'b0; m_ovf = 1'b0;
    repeat (3) step();
    check_state("reset");
    resetn = 1'b1;
    idle(10);

    // single byte with exact latency from the pin edge to empty falling
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (empty && lat < 3000) begin step(); lat++; end
      end
    join
    check("latency", 32'(lat), 32'(2 + H + 9 * C + 1));
    model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(8);
    check_state("single");
    read_n(1, "single_rd");
    check_state("single_pop");

    // 20-cycle glitch
    len = 0;
    fpga_rxd = 1'b0;
    fork
      begin repeat (20) step(); fpga_rxd = 1'b1; end
      begin
        int n;
        n = 0;
        while (!rx_busy && n < 100) begin step(); n++; end
        while (rx_busy && len < 300) begin step(); len++; end
      end
    join
    check("glitch_len", 32'(len), 32'(H));
    idle(20);
    check_state("glitch");

    // framing errors, clearing, and clear colliding with a new error
    send_with_pulse(8'h3C, 1'b0, 1'b0, 1'b0);
    check_state("ferr");
    pulse_clear();
    check_state("ferr_clr");
    send_with_pulse(8'h3C, 1'b0, 1'b0, 1'b1);
    check_state("ferr_set_wins");
    pulse_clear();

    // fill past capacity
    for (int i = 0; i <= DEPTH; i++) send_with_pulse(8'(i), 1'b1, 1'b0, 1'b0);
    check_state("overflow");
    pulse_clear();
    // full FIFO, pop during the push cycle
    send_with_pulse(8'h55, 1'b1, 1'b1, 1'b0);
    check_state("full_pushpop");
    read_n(DEPTH, "drain");
    check_state("drained");
    // empty FIFO, rd_en during the push cycle
    send_with_pulse(8'h66, 1'b1, 1'b1, 1'b0);
    check_state("empty_pushpop");

    // randomized frames, reads and clears
    for (int i = 0; i < 8; i++) begin
      send_with_pulse(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      check_state("rand");
      read_n($urandom_range(0, 2), "rand_rd");
    end
    send_with_pulse(8'h5A, 1'b1, 1'b0, 1'b0);

    // reset during data bit 4 (0xE6: bits 0..4 = 0,1,1,0,0), released with line low
    fpga_rxd = 1'b0;
    repeat (C) step();
    for (int i = 0; i < 5; i++) begin
      fpga_rxd = (i == 1 || i == 2);
      repeat ((i == 4) ? H : C) step();
    end
    resetn = 1'b0;
    #1;
    exp_q.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    check_state("mid_reset");
    repeat (3) step();
    resetn = 1'b1;
    busy_seen = 0;
    push_seen = 0;
    repeat (1200) begin
      step();
      if (rx_busy) busy_seen++;
      if (!empty)  push_seen++;
    end
    check("low_hold_busy", 32'(busy_seen), 32'd0);
    check("low_hold_push", 32'(push_seen), 32'd0);
    check_state("low_hold");
    idle(20);
    send_with_pulse(8'h81, 1'b1, 1'b0, 1'b0);
    check_state("after_reset");
    read_n(1, "final_rd");
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
